cpc_kbd_matrix: RTL and testbench

- Consumes the 80-bit CPC keyboard vector written by the HPS through the MMIO interface (cpc_keys_keys).
- Filters out transient HPS update glitches and holds a stable 10x8 key matrix.
- Serves the PSG port-A row read path (row select from PPI port C) with CPC active-low data.
- Emits a handshaked make/break event stream for the OSD/debug logic.

---
 rtl/cpc_kbd_pkg.sv | 21 ++
 rtl/cpc_kbd_event_scan.sv | 61 ++++++
 rtl/cpc_kbd_matrix.sv | 89 ++++++++
 tb/tb_cpc_kbd_matrix.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_kbd_pkg.sv
// Shared constants and types for the CPC keyboard matrix block.
package cpc_kbd_pkg;

  localparam int unsigned NUM_ROWS  = 10;
  localparam int unsigned ROW_BITS  = 8;
  localparam int unsigned NUM_KEYS  = 80;
  localparam int unsigned KEY_IDX_W = 7;

  localparam logic [ROW_BITS-1:0] ROW_IDLE = 8'hFF;

  typedef enum logic {
    SCAN,
    OFFER
  } scan_state_e;

  // Scan index successor, wrapping after the last key.
  function automatic logic [KEY_IDX_W-1:0] next_idx(input logic [KEY_IDX_W-1:0] idx);
    return (idx == KEY_IDX_W'(NUM_KEYS - 1)) ? '0 : idx + KEY_IDX_W'(1);
  endfunction

endpackage

// File: rtl/cpc_kbd_event_scan.sv
// Walks the key matrix one bit per cycle against a shadow copy and
// offers each difference as a make/break event over a valid/ready port.
module cpc_kbd_event_scan
  import cpc_kbd_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_KEYS-1:0]  matrix_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [KEY_IDX_W-1:0] evt_key_o,
  output logic                 evt_make_o
);

  scan_state_e          state_q;
  logic [KEY_IDX_W-1:0] idx_q;
  logic [NUM_KEYS-1:0]  shadow_q;
  logic                 evt_valid_q;
  logic [KEY_IDX_W-1:0] evt_key_q;
  logic                 evt_make_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= SCAN;
      idx_q       <= '0;
      shadow_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_make_q  <= 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (matrix_i[idx_q] != shadow_q[idx_q]) begin
            evt_key_q   <= idx_q;
            evt_make_q  <= matrix_i[idx_q];
            evt_valid_q <= 1'b1;
            state_q     <= OFFER;
          end else begin
            idx_q <= next_idx(idx_q);
          end
        end
        OFFER: begin
          // Shadow follows the delivered event, not the live matrix, so a
          // key that toggled back while offered is re-reported next pass.
          if (evt_ready_i) begin
            shadow_q[evt_key_q] <= evt_make_q;
            evt_valid_q         <= 1'b0;
            idx_q               <= next_idx(idx_q);
            state_q             <= SCAN;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_key_o   = evt_key_q;
  assign evt_make_o  = evt_make_q;

endmodule

// File: rtl/cpc_kbd_matrix.sv
// CPC keyboard matrix: synchronises the HPS key vector, debounces HPS update
// glitches, serves PSG row reads (active-low) and emits make/break events.
module cpc_kbd_matrix
  import cpc_kbd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_KEYS-1:0]  keys_i,
  input  logic [3:0]           row_sel_i,
  output logic [ROW_BITS-1:0]  row_data_o,
  output logic                 any_key_o,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [KEY_IDX_W-1:0] evt_key_o,
  output logic                 evt_make_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] matrix_q, matrix_d;
  logic [ROW_BITS-1:0] row_data_q, row_data_d;
  logic                any_key_q, any_key_d;

  // Stability filter: matrix only takes a candidate seen unchanged long enough.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    matrix_d = matrix_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      matrix_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Row read mux; rows beyond the matrix read as idle.
  always_comb begin
    row_data_d = ROW_IDLE;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (row_sel_i == 4'(r)) begin
        row_data_d = ~matrix_q[r*ROW_BITS +: ROW_BITS];
      end
    end
    any_key_d = |matrix_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q       <= '0;
      s2_q       <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      matrix_q   <= '0;
      row_data_q <= ROW_IDLE;
      any_key_q  <= 1'b0;
    end else begin
      s1_q       <= keys_i;
      s2_q       <= s1_q;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      matrix_q   <= matrix_d;
      row_data_q <= row_data_d;
      any_key_q  <= any_key_d;
    end
  end

  assign row_data_o = row_data_q;
  assign any_key_o  = any_key_q;

  cpc_kbd_event_scan u_event_scan (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .matrix_i    (matrix_q),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_key_o   (evt_key_o),
    .evt_make_o  (evt_make_o)
  );

endmodule

// File: tb/tb_cpc_kbd_matrix.sv
// Directed bench for cpc_kbd_matrix: filter latency, glitch rejection,
// row reads and the make/break event stream under backpressure and reset.
module tb_cpc_kbd_matrix;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [79:0] keys_i = '0;
  logic [3:0]  row_sel_i = 4'd0;
  logic [7:0]  row_data_o;
  logic        any_key_o;
  logic        evt_valid_o;
  logic        evt_ready_i = 1'b0;
  logic [6:0]  evt_key_o;
  logic        evt_make_o;

  int errors = 0;
  int checks = 0;

  cpc_kbd_matrix #(.STABLE_CYCLES(16), .CNT_W(5)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .keys_i      (keys_i),
    .row_sel_i   (row_sel_i),
    .row_data_o  (row_data_o),
    .any_key_o   (any_key_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_key_o   (evt_key_o),
    .evt_make_o  (evt_make_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (evt_valid_o === 1'b1) return;
      tick(1);
    end
  endtask

  task automatic handshake();
    evt_ready_i = 1'b1;
    tick(1);
    evt_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    checks++;
    if (any_key_o !== 1'b0) begin errors++; $display("FAIL reset_any_key: got %b want 0", any_key_o); end
    checks++;
    if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid_o); end
    for (int r = 0; r < 16; r++) begin
      row_sel_i = 4'(r);
      tick(1);
      checks++;
      if (row_data_o !== 8'hFF) begin errors++; $display("FAIL reset_row%0d: got %h want ff", r, row_data_o); end
    end
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (evt_valid_o !== 1'b0 || any_key_o !== 1'b0) seen = 1'b1;
      tick(1);
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_idle_200: activity seen=%b want 0", seen); end
  endtask

  task automatic test_press_release();
    row_sel_i = 4'd2;
    keys_i[18] = 1'b1;
    // First capturing edge is edge 1; matrix loads at edge 19, row read at edge 20.
    tick(19);
    checks++;
    if (row_data_o !== 8'hFF) begin errors++; $display("FAIL press_row_early: got %h want ff", row_data_o); end
    tick(1);
    checks++;
    if (row_data_o !== 8'hFB) begin errors++; $display("FAIL press_row: got %h want fb", row_data_o); end
    checks++;
    if (any_key_o !== 1'b1) begin errors++; $display("FAIL press_any_key: got %b want 1", any_key_o); end
    wait_valid(100);
    checks++;
    if (evt_valid_o !== 1'b1) begin errors++; $display("FAIL press_evt_timeout: valid=%b want 1", evt_valid_o); end
    checks++;
    if (evt_key_o !== 7'd18 || evt_make_o !== 1'b1)
      begin errors++; $display("FAIL press_evt: key=%0d make=%b want key=18 make=1", evt_key_o, evt_make_o); end
    handshake();
    checks++;
    if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL press_evt_drop: valid=%b want 0", evt_valid_o); end

    keys_i[18] = 1'b0;
    tick(20);
    checks++;
    if (row_data_o !== 8'hFF) begin errors++; $display("FAIL release_row: got %h want ff", row_data_o); end
    checks++;
    if (any_key_o !== 1'b0) begin errors++; $display("FAIL release_any_key: got %b want 0", any_key_o); end
    wait_valid(100);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd18 || evt_make_o !== 1'b0)
      begin errors++; $display("FAIL release_evt: valid=%b key=%0d make=%b want 1/18/0", evt_valid_o, evt_key_o, evt_make_o); end
    handshake();
  endtask

  task automatic test_glitch();
    bit seen;
    row_sel_i = 4'd0;
    evt_ready_i = 1'b1;
    seen = 1'b0;
    keys_i[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid_o !== 1'b0) seen = 1'b1;
      tick(1);
    end
    keys_i[5] = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (evt_valid_o !== 1'b0 || row_data_o !== 8'hFF) seen = 1'b1;
      tick(1);
    end
    evt_ready_i = 1'b0;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_leak: activity seen=%b want 0", seen); end
    checks++;
    if (row_data_o !== 8'hFF || any_key_o !== 1'b0)
      begin errors++; $display("FAIL glitch_row: row=%h any=%b want ff/0", row_data_o, any_key_o); end
  endtask

  task automatic test_back_to_back();
    bit bad;
    // Align the scan so it reaches index 79 just as the new matrix lands,
    // making key 3 the first difference found.
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
    tick(60);
    keys_i[3] = 1'b1;
    keys_i[77] = 1'b1;
    wait_valid(200);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd3 || evt_make_o !== 1'b1)
      begin errors++; $display("FAIL bp_first: valid=%b key=%0d make=%b want 1/3/1", evt_valid_o, evt_key_o, evt_make_o); end
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd3 || evt_make_o !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL bp_hold: unstable=%b want 0", bad); end
    handshake();
    checks++;
    if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL bp_accept: valid=%b want 0", evt_valid_o); end
    wait_valid(200);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd77 || evt_make_o !== 1'b1)
      begin errors++; $display("FAIL bp_second: valid=%b key=%0d make=%b want 1/77/1", evt_valid_o, evt_key_o, evt_make_o); end
    handshake();
    keys_i[3] = 1'b0;
    keys_i[77] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wait_valid(200);
      checks++;
      if (evt_valid_o !== 1'b1 || evt_make_o !== 1'b0 || (evt_key_o !== 7'd3 && evt_key_o !== 7'd77))
        begin errors++; $display("FAIL bp_break%0d: valid=%b key=%0d make=%b want 1/3or77/0", n, evt_valid_o, evt_key_o, evt_make_o); end
      handshake();
    end
  endtask

  task automatic test_toggle_offer();
    row_sel_i = 4'd12;
    keys_i[40] = 1'b1;
    wait_valid(200);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd40 || evt_make_o !== 1'b1)
      begin errors++; $display("FAIL toggle_make: valid=%b key=%0d make=%b want 1/40/1", evt_valid_o, evt_key_o, evt_make_o); end
    keys_i[40] = 1'b0;
    tick(40);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd40 || evt_make_o !== 1'b1)
      begin errors++; $display("FAIL toggle_held: valid=%b key=%0d make=%b want 1/40/1", evt_valid_o, evt_key_o, evt_make_o); end
    checks++;
    if (row_data_o !== 8'hFF) begin errors++; $display("FAIL toggle_row12: got %h want ff", row_data_o); end
    handshake();
    wait_valid(200);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd40 || evt_make_o !== 1'b0)
      begin errors++; $display("FAIL toggle_break: valid=%b key=%0d make=%b want 1/40/0", evt_valid_o, evt_key_o, evt_make_o); end
    handshake();
  endtask

  task automatic test_reset_mid_offer();
    row_sel_i = 4'd1;
    keys_i[9] = 1'b1;
    wait_valid(200);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd9 || evt_make_o !== 1'b1)
      begin errors++; $display("FAIL rst_pre: valid=%b key=%0d make=%b want 1/9/1", evt_valid_o, evt_key_o, evt_make_o); end
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    checks++;
    if (evt_valid_o !== 1'b0 || row_data_o !== 8'hFF)
      begin errors++; $display("FAIL rst_clear: valid=%b row=%h want 0/ff", evt_valid_o, row_data_o); end
    tick(20);
    checks++;
    if (row_data_o !== 8'hFD) begin errors++; $display("FAIL rst_row1: got %h want fd", row_data_o); end
    wait_valid(200);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd9 || evt_make_o !== 1'b1)
      begin errors++; $display("FAIL rst_remake: valid=%b key=%0d make=%b want 1/9/1", evt_valid_o, evt_key_o, evt_make_o); end
    handshake();
    keys_i[9] = 1'b0;
    wait_valid(200);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_key_o !== 7'd9 || evt_make_o !== 1'b0)
      begin errors++; $display("FAIL rst_break: valid=%b key=%0d make=%b want 1/9/0", evt_valid_o, evt_key_o, evt_make_o); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_back_to_back();
    test_toggle_offer();
    test_reset_mid_offer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
